// File: rtl/hex_dump_pkg.sv
// rtl/hex_dump_pkg.sv - shared state encodings and ASCII constants for the hex dump transmitter
package hex_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_SEP  = 3'd3,
        ST_CR   = 3'd4,
        ST_LF   = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;

endpackage

// File: rtl/hex_dump_tx_if.sv
// rtl/hex_dump_tx_if.sv - byte input, flush and UART write signals of the hex dump transmitter
interface hex_dump_tx_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       uart_busy;
    logic       uart_wr;
    logic [7:0] uart_data;

    modport slave (
        input  in_valid, in_data, flush, uart_busy,
        output in_ready, uart_wr, uart_data
    );

    modport master (
        output in_valid, in_data, flush, uart_busy,
        input  in_ready, uart_wr, uart_data
    );
endinterface

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit nibble to uppercase ASCII hex digit
module nibble_to_ascii
    import hex_dump_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    // digits 0-9 map onto '0'.., 10-15 onto 'A'..
    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASC_0 + {4'd0, nib_i};
        end else begin
            ascii_o = ASC_A + {4'd0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_dump_tx.sv
// rtl/hex_dump_tx.sv - streams accepted bytes to a UART as hex text lines
module hex_dump_tx
    import hex_dump_pkg::*;
#(
    parameter int         BYTES_PER_LINE = 16,
    parameter logic [7:0] SEP_CHAR       = 8'h20
) (
    input  logic            clk,
    input  logic            resetq,
    hex_dump_tx_if.slave    bus
);

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    state_t     state_q, state_d;
    state_t     nxt_q, nxt_d;
    logic [7:0] col_q, col_d;
    logic [7:0] byte_q, byte_d;
    logic       wr_q, wr_d;
    logic [7:0] data_q, data_d;

    logic [3:0] nib;
    logic [7:0] hex_char;
    logic [7:0] emit_char;

    assign nib = (state_q == ST_HI) ? byte_q[7:4] : byte_q[3:0];

    nibble_to_ascii u_nib (
        .nib_i   (nib),
        .ascii_o (hex_char)
    );

    assign bus.in_ready  = resetq && (state_q == ST_IDLE);
    assign bus.uart_wr   = wr_q;
    assign bus.uart_data = data_q;

    // character belonging to the current emit state
    always_comb begin
        emit_char = hex_char;
        case (state_q)
            ST_SEP:  emit_char = SEP_CHAR;
            ST_CR:   emit_char = ASC_CR;
            ST_LF:   emit_char = ASC_LF;
            default: emit_char = hex_char;
        endcase
    end

    // next-state, column and strobe logic; every emit is followed by one GAP cycle
    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        col_d   = col_q;
        byte_d  = byte_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    byte_d  = bus.in_data;
                    state_d = ST_HI;
                end else if (bus.flush && (col_q != 8'd0)) begin
                    col_d   = 8'd0;
                    state_d = ST_CR;
                end
            end
            ST_HI, ST_LO, ST_SEP, ST_CR, ST_LF: begin
                if (!bus.uart_busy) begin
                    wr_d    = 1'b1;
                    data_d  = emit_char;
                    state_d = ST_GAP;
                    case (state_q)
                        ST_HI: nxt_d = ST_LO;
                        ST_LO: begin
                            if (col_q == LAST_COL) begin
                                nxt_d = ST_CR;
                                col_d = 8'd0;
                            end else begin
                                nxt_d = ST_SEP;
                                col_d = col_q + 8'd1;
                            end
                        end
                        ST_CR:   nxt_d = ST_LF;
                        default: nxt_d = ST_IDLE;
                    endcase
                end
            end
            ST_GAP:  state_d = nxt_q;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            nxt_q   <= ST_IDLE;
            col_q   <= 8'd0;
            byte_q  <= 8'h00;
            wr_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            col_q   <= col_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_hex_dump_tx.sv
// tb/tb_hex_dump_tx.sv - directed self-checking bench for hex_dump_tx
module tb_hex_dump_tx;

    logic clk;
    logic resetq;

    hex_dump_tx_if bus_if ();

    hex_dump_tx #(
        .BYTES_PER_LINE (16),
        .SEP_CHAR       (8'h20)
    ) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;
    int cyc;
    int dbl_cnt;
    logic prev_wr;
    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] exp_q[$];

    // capture every UART strobe and flag back-to-back strobes
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus_if.uart_wr === 1'b1) begin
            out_q.push_back(bus_if.uart_data);
            out_cyc.push_back(cyc);
            if (prev_wr === 1'b1) dbl_cnt = dbl_cnt + 1;
        end
        prev_wr = bus_if.uart_wr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) chk($sformatf("%s_c%0d", tag, i), {24'd0, out_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        step();
        while (bus_if.in_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    int acc_cyc;

    task automatic send_byte(input logic [7:0] b, input string tag);
        wait_idle(tag);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic do_reset();
        resetq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetq = 1'b1;
        clear_out();
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [7:0] v;
        v = {4'd0, n};
        return (n < 4'd10) ? (8'h30 + v) : (8'h37 + v);
    endfunction

    int n_wait;
    int chg;
    int rel_cyc;
    logic [7:0] d0;

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; dbl_cnt = 0; prev_wr = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.in_data = 8'h00;
        bus_if.flush = 1'b0; bus_if.uart_busy = 1'b0;
        resetq = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        step();
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        chk("rst_uart_wr", {31'd0, bus_if.uart_wr}, 32'd0);
        chk("rst_uart_data", {24'd0, bus_if.uart_data}, 32'h00);
        @(posedge clk);
        #1;
        resetq = 1'b1;
        step();
        chk("rel_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        clear_out();

        // single byte 0x3A: latency and strobe spacing
        send_byte(8'h3A, "b3a");
        wait_idle("b3a");
        exp_q = '{8'h33, 8'h41, 8'h20};
        check_out("b3a");
        if (out_cyc.size() == 3) begin
            chk("b3a_latency", out_cyc[0] - acc_cyc, 32'd2);
            chk("b3a_gap1", out_cyc[1] - out_cyc[0], 32'd2);
            chk("b3a_gap2", out_cyc[2] - out_cyc[1], 32'd2);
        end

        // full line of 16 bytes
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), "line");
        wait_idle("line");
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(hexc(4'(i)));
            if (i < 15) exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check_out("line");
        out_q.delete();
        bus_if.flush = 1'b1;
        repeat (10) step();
        bus_if.flush = 1'b0;
        chk("line_col0_flush", out_q.size(), 32'd0);

        // three bytes then flush; second flush at column zero is silent
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'(i), "fl");
        wait_idle("fl");
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        wait_idle("fl2");
        exp_q = '{8'h30, 8'h30, 8'h20, 8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h20, 8'h0D, 8'h0A};
        check_out("fl");
        out_q.delete();
        bus_if.flush = 1'b1;
        repeat (10) step();
        bus_if.flush = 1'b0;
        chk("fl_second", out_q.size(), 32'd0);

        // UART busy holds the HI state
        do_reset();
        bus_if.uart_busy = 1'b1;
        send_byte(8'h3A, "busy");
        step();
        d0 = bus_if.uart_data;
        chg = 0;
        repeat (100) begin
            step();
            if (bus_if.uart_data !== d0) chg++;
        end
        chk("busy_no_wr", out_q.size(), 32'd0);
        chk("busy_data_stable", chg, 32'd0);
        bus_if.uart_busy = 1'b0;
        rel_cyc = cyc;
        wait_idle("busy");
        exp_q = '{8'h33, 8'h41, 8'h20};
        check_out("busy");
        if (out_cyc.size() > 0) chk("busy_release_lat", out_cyc[0] - rel_cyc, 32'd1);

        // reset between HI and LO strobes of 0xC5
        do_reset();
        send_byte(8'hC5, "mid");
        n_wait = 0;
        while (out_q.size() == 0 && n_wait < 100) begin
            step();
            n_wait++;
        end
        if (n_wait >= 100) chk("mid_timeout", 32'd0, 32'd1);
        resetq = 1'b0;
        @(posedge clk);
        #1;
        resetq = 1'b1;
        repeat (20) step();
        exp_q = '{8'h43};
        check_out("mid");
        clear_out();
        send_byte(8'h01, "mid2");
        wait_idle("mid2");
        exp_q = '{8'h30, 8'h31, 8'h20};
        check_out("mid2");

        // byte and flush together: byte first, then the flush
        do_reset();
        send_byte(8'h10, "pri");
        send_byte(8'h11, "pri");
        wait_idle("pri");
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'hFF;
        bus_if.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        wait_idle("pri2");
        repeat (20) step();
        bus_if.flush = 1'b0;
        wait_idle("pri3");
        exp_q = '{8'h31, 8'h30, 8'h20, 8'h31, 8'h31, 8'h20, 8'h46, 8'h46, 8'h20, 8'h0D, 8'h0A};
        check_out("pri");

        chk("no_double_strobe", dbl_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
